// File: rtl/vga_pixel_fetch_pkg.sv
`default_nettype none
// ==== vga_pixel_fetch_pkg : shared VGA timing, RGB565 layout and fetch FSM encodings -- rev 1.0 ====
package vga_pixel_fetch_pkg;

   localparam int H_ACT_DEF   = 640;
   localparam int V_ACT_DEF   = 480;
   localparam int H_FRONT     = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BACK      = 48;
   localparam int V_FRONT     = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BACK      = 33;

   localparam int RGB_R_MSB   = 15;
   localparam int RGB_R_LSB   = 11;
   localparam int RGB_G_MSB   = 10;
   localparam int RGB_G_LSB   = 5;
   localparam int RGB_B_MSB   = 4;
   localparam int RGB_B_LSB   = 0;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      FETCH   = 2'd1,
      DRAIN   = 2'd2
   } fetch_state_e;

   // Replicate MSBs into the LSBs so full scale maps to full scale.
   function automatic logic [29:0] rgb565_expand(input logic [15:0] px);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = px[RGB_R_MSB:RGB_R_LSB];
      g = px[RGB_G_MSB:RGB_G_LSB];
      b = px[RGB_B_MSB:RGB_B_LSB];
      return {r, r, g, g[5:2], b, b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_fetch_fifo.sv
`default_nettype none
// ==== pixel_fifo : synchronous show-ahead FIFO with occupancy count and flush -- rev 1.0 ====
module pixel_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   wr_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   rd_i,
   output logic [WIDTH-1:0]       rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_rd;

   assign do_rd = rd_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_i)  wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_i && !do_rd)      count_d = count_q + (AW+1)'(1);
         else if (!wr_i && do_rd) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign empty_o   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ==== vga_pixel_fetch : prefetches RGB565 framebuffer words and serves expanded pixels -- rev 1.0 ====
module vga_pixel_fetch
   import vga_pixel_fetch_pkg::*;
#(
   parameter int H_ACT      = H_ACT_DEF,
   parameter int V_ACT      = V_ACT_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iRequest,
   input  logic        iVGA_V_SYNC,
   output logic [9:0]  oRed,
   output logic [9:0]  oGreen,
   output logic [9:0]  oBlue,
   output logic        oMem_Read,
   output logic [18:0] oMem_Addr,
   input  logic        iMem_Wait,
   input  logic        iMem_RdValid,
   input  logic [15:0] iMem_RdData,
   output logic        oUnderflow
);
   localparam int          CW        = $clog2(FIFO_DEPTH);
   localparam int          OW        = CW + 2;
   localparam logic [18:0] LAST_ADDR = 19'(H_ACT * V_ACT - 1);

   fetch_state_e   state_q, state_d;
   logic [1:0]     vs_q;
   logic [18:0]    addr_q, addr_d;
   logic [OW-1:0]  outst_q, outst_d;
   logic [OW-1:0]  disc_q, disc_d;
   logic [OW-1:0]  in_flight;
   logic [9:0]     red_q, green_q, blue_q;
   logic           underflow_q;
   logic           sof, mem_read, accept, fifo_wr, fifo_pop, fifo_empty;
   logic [CW:0]    fifo_count;
   logic [15:0]    fifo_head;

   assign sof       = vs_q[1] && !vs_q[0];
   assign mem_read  = (state_q == FETCH) && !sof &&
                      (({1'b0, fifo_count} + outst_q) < OW'(FIFO_DEPTH));
   assign accept    = mem_read && !iMem_Wait;
   assign fifo_wr   = iMem_RdValid && !sof && (disc_q == '0) && (outst_q != '0);
   assign fifo_pop  = iRequest && !fifo_empty;
   assign in_flight = disc_q + outst_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      outst_d = outst_q;
      disc_d  = disc_q;
      if (sof) begin
         state_d = FETCH;
         addr_d  = '0;
         outst_d = '0;
         // A beat landing this very cycle is dropped now, so it is not owed again.
         disc_d  = (iMem_RdValid && in_flight != '0) ? in_flight - OW'(1) : in_flight;
      end else begin
         if (accept) addr_d = addr_q + 19'd1;
         case ({accept, fifo_wr})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: ;
         endcase
         if (iMem_RdValid && disc_q != '0) disc_d = disc_q - OW'(1);
         case (state_q)
            FETCH:   if (accept && addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (outst_q == '0) state_d = WAIT_VS;
            default: ;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q <= WAIT_VS;
         vs_q    <= 2'b00;
         addr_q  <= '0;
         outst_q <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         vs_q    <= {vs_q[0], iVGA_V_SYNC};
         addr_q  <= addr_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         underflow_q <= 1'b0;
      end else if (iRequest) begin
         if (fifo_empty) begin
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            underflow_q <= 1'b1;
         end else begin
            {red_q, green_q, blue_q} <= rgb565_expand(fifo_head);
         end
      end
   end

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_i     (iCLK),
      .rst_ni    (iRST_N),
      .flush_i   (sof),
      .wr_i      (fifo_wr),
      .wr_data_i (iMem_RdData),
      .rd_i      (fifo_pop),
      .rd_data_o (fifo_head),
      .count_o   (fifo_count),
      .empty_o   (fifo_empty)
   );

   assign oMem_Read  = mem_read;
   assign oMem_Addr  = addr_q;
   assign oRed       = red_q;
   assign oGreen     = green_q;
   assign oBlue      = blue_q;
   assign oUnderflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ==== tb_vga_pixel_fetch : directed self-checking bench with a latency/stall memory model -- rev 1.0 ====
module tb_vga_pixel_fetch;
   import vga_pixel_fetch_pkg::*;

   localparam int HA    = 8;
   localparam int VA    = 4;
   localparam int DEPTH = 16;
   localparam int NPIX  = HA * VA;

   logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, vsync = 1'b1;
   logic [9:0]  red, green, blue;
   logic        mrd, unf;
   logic [18:0] maddr;
   logic        mwait = 1'b0, rdv = 1'b0;
   logic [15:0] rdd = '0;

   int n_checks = 0, n_pass = 0;

   vga_pixel_fetch #(.H_ACT(HA), .V_ACT(VA), .FIFO_DEPTH(DEPTH)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iRequest(req), .iVGA_V_SYNC(vsync),
      .oRed(red), .oGreen(green), .oBlue(blue),
      .oMem_Read(mrd), .oMem_Addr(maddr), .iMem_Wait(mwait),
      .iMem_RdValid(rdv), .iMem_RdData(rdd), .oUnderflow(unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] word_of(input logic [18:0] a);
      return (a == 19'd0) ? 16'hF800 : (16'hA5A5 ^ {a[7:0], a[7:0]});
   endfunction

   function automatic logic [29:0] expand(input logic [15:0] w);
      return {w[15:11], w[15:11], w[10:5], w[10:7], w[4:0], w[4:0]};
   endfunction

   // Memory model: accepts on oMem_Read & !iMem_Wait, returns in order after lat cycles.
   typedef struct { int due; logic [15:0] data; } beat_t;
   beat_t       q[$];
   int          cyc = 0, lat = 1;
   logic        stall = 1'b0, epoch = 1'b0;
   int          acc_count = 0, max_fly = 0, addr_err = 0, stable_err = 0;
   logic [18:0] exp_addr = '0, first_addr = '0, last_addr = '0, prev_addr = '0;
   logic        prev_hold = 1'b0, saw_drain = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      mwait = stall;
      if (prev_hold && (!mrd || maddr != prev_addr)) stable_err++;
      prev_hold = mrd && mwait;
      prev_addr = maddr;
      if (mrd && !mwait) begin
         if (acc_count == 0) first_addr = maddr;
         if (maddr != exp_addr) addr_err++;
         exp_addr  = maddr + 19'd1;
         last_addr = maddr;
         acc_count++;
         q.push_back('{cyc + 1 + lat, epoch ? 16'h07E0 : word_of(maddr)});
         if (q.size() > max_fly) max_fly = q.size();
      end
      if (q.size() != 0 && q[0].due == cyc + 1) begin
         rdv = 1'b1;
         rdd = q[0].data;
         void'(q.pop_front());
      end else begin
         rdv = 1'b0;
      end
      if (dut.state_q == DRAIN) saw_drain = 1'b1;
   end

   task automatic wait_state(input fetch_state_e s, input int budget, input string tag);
      int i;
      i = 0;
      while (dut.state_q != s && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(tag, 32'(dut.state_q), 32'(s));
   endtask

   task automatic pop_pixel();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_read", 32'(mrd), 0);
      check("rst_addr", 32'(maddr), 0);
      check("rst_rgb", {red, green, blue}, 0);
      check("rst_unf", 32'(unf), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_read", 32'(mrd), 0);

      // Frame A: fill the FIFO with zero wait, latency 1
      acc_count = 0; exp_addr = '0; max_fly = 0; addr_err = 0;
      vsync = 1'b0;
      wait_state(FETCH, 10, "fa_fetch");
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (40) @(negedge clk);
      check("first_addr", 32'(first_addr), 0);
      check("fill_reads", acc_count, 16);
      check("fill_count", 32'(dut.u_fifo.count_q), 16);
      check("full_no_read", 32'(mrd), 0);
      check("max_inflight_le16", 32'(max_fly <= 16), 1);

      // First pixel is F800 -> pure red; held while iRequest is low
      stall = 1'b1;
      pop_pixel();
      check("px0_red", 32'(red), 32'h3FF);
      check("px0_green", 32'(green), 0);
      check("px0_blue", 32'(blue), 0);
      @(negedge clk);
      check("px0_hold", {red, green, blue}, {10'h3FF, 20'h0});

      stable_err = 0;
      repeat (5) @(negedge clk);
      check("stall_read", 32'(mrd), 1);
      check("stall_addr", 32'(maddr), 16);
      check("stall_stable", stable_err, 0);
      check("stall_no_accept", acc_count, 16);
      stall = 1'b0;

      for (int i = 1; i < NPIX; i++) begin
         pop_pixel();
         check($sformatf("px%0d", i), {2'b00, red, green, blue}, {2'b00, expand(word_of(19'(i)))});
      end
      wait_state(WAIT_VS, 60, "frame_done");
      check("last_addr", 32'(last_addr), NPIX - 1);
      check("frame_reads", acc_count, NPIX);
      check("addr_sequence", addr_err, 0);
      check("saw_drain", 32'(saw_drain), 1);
      check("outstanding_zero", 32'(dut.outst_q), 0);
      check("model_drained", q.size(), 0);
      check("done_no_read", 32'(mrd), 0);
      check("no_unf_yet", 32'(unf), 0);

      // Underflow on an empty FIFO; flag is sticky
      pop_pixel();
      check("unf_rgb_zero", {red, green, blue}, 0);
      check("unf_set", 32'(unf), 1);
      repeat (5) @(negedge clk);
      check("unf_sticky", 32'(unf), 1);

      // Frame B: 3 reads in flight (latency 4) when the next frame starts
      lat = 4; stall = 1'b1; epoch = 1'b1;
      vsync = 1'b0;
      wait_state(FETCH, 10, "fb_fetch");
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      check("fb_read_pending", 32'(mrd), 1);
      acc_count = 0;
      stall = 1'b0;
      repeat (3) @(negedge clk);
      stall = 1'b1; epoch = 1'b0; vsync = 1'b0;
      repeat (12) @(negedge clk);
      check("fb_three_issued", acc_count, 3);
      check("fb_beats_returned", q.size(), 0);
      check("fb_discarded", 32'(dut.u_fifo.count_q), 0);
      vsync = 1'b1;
      stall = 1'b0;
      repeat (10) @(negedge clk);
      pop_pixel();
      check("fb_px0", {red, green, blue}, {10'h3FF, 20'h0});
      pop_pixel();
      check("fb_px1", {2'b00, red, green, blue}, {2'b00, expand(word_of(19'd1))});
      check("fb_unf_still", 32'(unf), 1);

      // Reset mid-frame abandons in-flight beats
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst2_unf", 32'(unf), 0);
      check("rst2_read", 32'(mrd), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst2_fifo_empty", 32'(dut.u_fifo.count_q), 0);
      check("rst2_state", 32'(dut.state_q), 32'(WAIT_VS));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
